// File: rtl/timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_pkg : shared state encoding and BCD load conversion for timer_ctrl  |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [5:0] MAX_VAL = 6'd59;

  // Values above 59 saturate so a bad operator entry still loads a legal mm/ss field.
  function automatic logic [7:0] bin2bcd(input logic [5:0] num);
    logic [5:0] v;
    logic [5:0] tens;
    logic [5:0] units;
    v     = (num > MAX_VAL) ? MAX_VAL : num;
    tens  = v / 6'd10;
    units = v % 6'd10;
    return {tens[3:0], units[3:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_ctrl_if : operator strobes, datapath flags and datapath commands    |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
interface timer_ctrl_if;
  import timer_pkg::*;

  logic [5:0] num;
  logic       get_min;
  logic       get_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic       fast;
  logic       up;
  logic       cnt_zero;
  logic       cnt_max;
  logic [7:0] ld_digits;
  logic       ld_min;
  logic       ld_sec;
  logic       cnt_en;
  logic       cnt_up;
  logic       cnt_clr;
  logic       led;
  state_e     state;

  modport master (
    output num, get_min, get_sec, start, pause, clear, fast, up, cnt_zero, cnt_max,
    input  ld_digits, ld_min, ld_sec, cnt_en, cnt_up, cnt_clr, led, state
  );

  modport slave (
    input  num, get_min, get_sec, start, pause, clear, fast, up, cnt_zero, cnt_max,
    output ld_digits, ld_min, ld_sec, cnt_en, cnt_up, cnt_clr, led, state
  );
endinterface
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_prescaler : tick divider with hold, sync clear and fast select      |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int FAST_DIV = 1_000_000
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic i_en,
  input  wire logic i_clr,
  input  wire logic i_fast,
  output logic      o_tick
);

  localparam int MAX_DIV = (TICK_DIV > FAST_DIV) ? TICK_DIV : FAST_DIV;
  localparam int CW      = $clog2(MAX_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;

  // >= rather than == so a switch to the short divisor mid-count still ticks.
  assign w_last = i_fast ? FAST_LAST : TICK_LAST;
  assign o_tick = i_en && (r_cnt >= w_last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_ctrl : kitchen-timer sequencer - edge detect, FSM, command strobes  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int FAST_DIV = 1_000_000
) (
  input  wire logic   clock,
  input  wire logic   reset,
  timer_ctrl_if.slave bus
);

  state_e     r_state;
  logic [7:0] r_ld_digits;
  logic       r_ld_min;
  logic       r_ld_sec;
  logic       r_cnt_en;
  logic       r_cnt_up;
  logic       r_cnt_clr;
  logic       r_led;
  logic       r_prev_min;
  logic       r_prev_sec;
  logic       r_prev_start;
  logic       r_prev_pause;
  logic       r_prev_clear;

  logic w_min_e;
  logic w_sec_e;
  logic w_start_e;
  logic w_pause_e;
  logic w_clr_e;
  logic w_load;
  logic w_ps_en;
  logic w_ps_clr;
  logic w_tick;
  logic w_start_term;
  logic w_run_term;

  assign w_min_e   = bus.get_min & ~r_prev_min;
  assign w_sec_e   = bus.get_sec & ~r_prev_sec;
  assign w_start_e = bus.start   & ~r_prev_start;
  assign w_pause_e = bus.pause   & ~r_prev_pause;
  assign w_clr_e   = bus.clear   & ~r_prev_clear;
  assign w_load    = w_min_e | w_sec_e;

  assign w_start_term = bus.up ? bus.cnt_max : bus.cnt_zero;
  assign w_run_term   = r_cnt_up ? bus.cnt_max : bus.cnt_zero;

  // The prescaler holds on the cycle RUN is left so a resume continues from that count.
  assign w_ps_en  = (r_state == ST_RUN) && !w_pause_e && !w_clr_e;
  assign w_ps_clr = w_clr_e || ((r_state == ST_IDLE) && w_start_e && !w_load);

  timer_prescaler #(
    .TICK_DIV (TICK_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .i_en   (w_ps_en),
    .i_clr  (w_ps_clr),
    .i_fast (bus.fast),
    .o_tick (w_tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ld_digits  <= '0;
      r_ld_min     <= 1'b0;
      r_ld_sec     <= 1'b0;
      r_cnt_en     <= 1'b0;
      r_cnt_up     <= 1'b0;
      r_cnt_clr    <= 1'b0;
      r_led        <= 1'b0;
      r_prev_min   <= 1'b0;
      r_prev_sec   <= 1'b0;
      r_prev_start <= 1'b0;
      r_prev_pause <= 1'b0;
      r_prev_clear <= 1'b0;
    end else begin
      r_prev_min   <= bus.get_min;
      r_prev_sec   <= bus.get_sec;
      r_prev_start <= bus.start;
      r_prev_pause <= bus.pause;
      r_prev_clear <= bus.clear;
      r_ld_min     <= 1'b0;
      r_ld_sec     <= 1'b0;
      r_cnt_en     <= 1'b0;
      r_cnt_clr    <= 1'b0;
      if (w_clr_e) begin
        r_state   <= ST_IDLE;
        r_cnt_clr <= 1'b1;
        r_led     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_load) begin
              r_ld_min    <= w_min_e;
              r_ld_sec    <= w_sec_e;
              r_ld_digits <= bin2bcd(bus.num);
            end else if (w_start_e) begin
              r_cnt_up <= bus.up;
              if (w_start_term) begin
                r_state <= ST_DONE;
                r_led   <= 1'b1;
              end else begin
                r_state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (w_pause_e) begin
              r_state <= ST_PAUSE;
            end else if (w_tick) begin
              if (w_run_term) begin
                r_state <= ST_DONE;
                r_led   <= 1'b1;
              end else begin
                r_cnt_en <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (w_pause_e || w_start_e) begin
              r_state <= ST_RUN;
            end
          end
          ST_DONE: begin
            if (w_load) begin
              r_ld_min    <= w_min_e;
              r_ld_sec    <= w_sec_e;
              r_ld_digits <= bin2bcd(bus.num);
              r_state     <= ST_IDLE;
              r_led       <= 1'b0;
            end else if (w_start_e) begin
              r_state <= ST_IDLE;
              r_led   <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ld_digits = r_ld_digits;
  assign bus.ld_min    = r_ld_min;
  assign bus.ld_sec    = r_ld_sec;
  assign bus.cnt_en    = r_cnt_en;
  assign bus.cnt_up    = r_cnt_up;
  assign bus.cnt_clr   = r_cnt_clr;
  assign bus.led       = r_led;
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_timer_ctrl : directed checks of timer_ctrl with TICK_DIV=10, FAST_DIV=2|
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_timer_ctrl;
  import timer_pkg::*;

  logic clock;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_cyc;
  int   n_seen;

  timer_ctrl_if bus ();

  timer_ctrl #(
    .TICK_DIV (10),
    .FAST_DIV (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic chkst(input string tag, input state_e obs, input state_e exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Returns cycles until cnt_en is seen high; 999 if the budget expires.
  task automatic wait_en(output int cycles);
    cycles = 999;
    for (int k = 1; k <= 64; k++) begin
      step(1);
      if (bus.cnt_en === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    n_total      = 0;
    n_pass       = 0;
    reset        = 1'b0;
    bus.num      = 6'd0;
    bus.get_min  = 1'b0;
    bus.get_sec  = 1'b0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.clear    = 1'b0;
    bus.fast     = 1'b0;
    bus.up       = 1'b0;
    bus.cnt_zero = 1'b0;
    bus.cnt_max  = 1'b0;
    #3;
    chkst("reset_state", bus.state, ST_IDLE);
    chk8("reset_digits", bus.ld_digits, 8'h00);
    chk1("reset_led", bus.led, 1'b0);
    chk1("reset_cnt_up", bus.cnt_up, 1'b0);
    chk1("reset_cnt_en", bus.cnt_en, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step(1);

    // Loads in IDLE, including saturation and a double strobe.
    bus.num = 6'd37; bus.get_sec = 1'b1;
    step(1);
    chk1("load37_ld_sec", bus.ld_sec, 1'b1);
    chk1("load37_ld_min", bus.ld_min, 1'b0);
    chk8("load37_digits", bus.ld_digits, 8'h37);
    step(1);
    chk1("load37_pulse_len", bus.ld_sec, 1'b0);
    bus.get_sec = 1'b0; bus.num = 6'd63; bus.get_min = 1'b1;
    step(1);
    chk1("load63_ld_min", bus.ld_min, 1'b1);
    chk8("load63_digits", bus.ld_digits, 8'h59);
    bus.get_min = 1'b0;
    step(1);
    bus.num = 6'd5; bus.get_min = 1'b1; bus.get_sec = 1'b1;
    step(1);
    chk1("load_both_min", bus.ld_min, 1'b1);
    chk1("load_both_sec", bus.ld_sec, 1'b1);
    chk8("load_both_digits", bus.ld_digits, 8'h05);
    bus.get_min = 1'b0; bus.get_sec = 1'b0;
    step(1);

    // Load in the same cycle as start suppresses the start.
    bus.num = 6'd9; bus.get_sec = 1'b1; bus.start = 1'b1;
    step(1);
    chkst("load_beats_start", bus.state, ST_IDLE);
    bus.get_sec = 1'b0; bus.start = 1'b0;
    step(1);

    // Countdown at TICK_DIV.
    bus.start = 1'b1;
    step(1);
    chkst("cd_state_run", bus.state, ST_RUN);
    chk1("cd_cnt_up", bus.cnt_up, 1'b0);
    bus.start = 1'b0;
    wait_en(n_cyc);
    chkn("cd_first_tick", n_cyc, 10);
    step(1);
    chk1("cd_en_one_cycle", bus.cnt_en, 1'b0);
    wait_en(n_cyc);
    chkn("cd_second_tick", n_cyc, 9);
    bus.cnt_zero = 1'b1;
    n_seen = 0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      if (bus.cnt_en === 1'b1) n_seen++;
    end
    chkst("cd_still_run", bus.state, ST_RUN);
    step(1);
    if (bus.cnt_en === 1'b1) n_seen++;
    chkst("cd_done_state", bus.state, ST_DONE);
    chk1("cd_done_led", bus.led, 1'b1);
    chkn("cd_no_en_at_zero", n_seen, 0);
    bus.start = 1'b1;
    step(1);
    chkst("cd_done_to_idle", bus.state, ST_IDLE);
    chk1("cd_led_off", bus.led, 1'b0);
    bus.start = 1'b0;
    step(1);

    // Start at terminal count, then leave DONE by start and by load.
    bus.start = 1'b1;
    step(1);
    chkst("term_done", bus.state, ST_DONE);
    chk1("term_led", bus.led, 1'b1);
    chk1("term_no_en", bus.cnt_en, 1'b0);
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    chkst("term_restart_idle", bus.state, ST_IDLE);
    chk1("term_restart_led", bus.led, 1'b0);
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0; bus.num = 6'd12; bus.get_min = 1'b1;
    step(1);
    chkst("done_load_idle", bus.state, ST_IDLE);
    chk1("done_load_strobe", bus.ld_min, 1'b1);
    chk8("done_load_digits", bus.ld_digits, 8'h12);
    chk1("done_load_led", bus.led, 1'b0);
    bus.get_min = 1'b0; bus.cnt_zero = 1'b0;
    step(1);

    // Pause at prescaler count 4, hold 50 cycles, resume.
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(4);
    bus.pause = 1'b1;
    step(1);
    chkst("pause_state", bus.state, ST_PAUSE);
    bus.pause = 1'b0;
    n_seen = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (bus.cnt_en === 1'b1) n_seen++;
    end
    chkn("pause_no_en", n_seen, 0);
    chkst("pause_held", bus.state, ST_PAUSE);
    bus.pause = 1'b1;
    step(1);
    chkst("resume_state", bus.state, ST_RUN);
    bus.pause = 1'b0;
    wait_en(n_cyc);
    chkn("resume_tick", n_cyc, 6);

    // Clear back to IDLE, then fast up-count to max.
    bus.clear = 1'b1;
    step(1);
    chkst("clear_idle", bus.state, ST_IDLE);
    chk1("clear_pulse", bus.cnt_clr, 1'b1);
    bus.clear = 1'b0;
    step(1);
    chk1("clear_pulse_len", bus.cnt_clr, 1'b0);
    bus.up = 1'b1; bus.fast = 1'b1; bus.start = 1'b1;
    step(1);
    chkst("fast_run", bus.state, ST_RUN);
    chk1("fast_cnt_up", bus.cnt_up, 1'b1);
    bus.start = 1'b0;
    wait_en(n_cyc);
    chkn("fast_first_tick", n_cyc, 2);
    wait_en(n_cyc);
    chkn("fast_second_tick", n_cyc, 2);
    bus.cnt_max = 1'b1;
    step(1);
    chkst("fast_still_run", bus.state, ST_RUN);
    step(1);
    chkst("fast_done", bus.state, ST_DONE);
    chk1("fast_done_no_en", bus.cnt_en, 1'b0);
    chk1("fast_done_led", bus.led, 1'b1);

    // Clear outranks pause in the same cycle.
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0; bus.cnt_max = 1'b0; bus.fast = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chkst("prio_run", bus.state, ST_RUN);
    step(3);
    bus.pause = 1'b1; bus.clear = 1'b1;
    step(1);
    chkst("prio_idle", bus.state, ST_IDLE);
    chk1("prio_clr", bus.cnt_clr, 1'b1);
    bus.pause = 1'b0; bus.clear = 1'b0;
    step(1);

    // Asynchronous reset mid-run while cnt_en is high.
    bus.fast = 1'b1; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_en(n_cyc);
    chkn("rst_pre_tick", n_cyc, 2);
    reset = 1'b0;
    #1;
    chkst("rst_async_state", bus.state, ST_IDLE);
    chk1("rst_async_en", bus.cnt_en, 1'b0);
    chk1("rst_async_up", bus.cnt_up, 1'b0);
    chk8("rst_async_digits", bus.ld_digits, 8'h00);
    chk1("rst_async_led", bus.led, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the kitchen-timer BCD mm:ss counter datapath. Converts operator strobes into single-cycle load/count/clear commands. Generates the 1 Hz (or fast) count tick from the system clock, and detects terminal count to drive the done LED. Sits between the button front end (already debounced) and the counter datapath, which reports its `cnt_zero`/`cnt_max` flags back.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per normal tick; must be ≥ 2.
- `FAST_DIV`, default 1_000_000: clock cycles per tick when `fast`=1; must be ≥ 2.
- `clock`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `num`  in  6  binary value to load into minutes or seconds.
- `get_min`, `get_sec`, `start`, `pause`, `clear`  in  1 each  level inputs; only rising edges act.
- `fast`  in  1  level input; selects `FAST_DIV`.
- `up`  in  1  level input; count direction, latched at start.
- `cnt_zero`  in  1  datapath reads 00:00.
- `cnt_max`  in  1  datapath reads 59:59.
- `ld_digits`  out  8  BCD load value: [7:4] tens, [3:0] units.
- `ld_min`, `ld_sec`  out  1 each  one-cycle load strobes.
- `cnt_en`  out  1  one-cycle count pulse.
- `cnt_up`  out  1  latched direction.
- `cnt_clr`  out  1  one-cycle datapath clear.
- `led`  out  1  done indicator.
- `state`  out  2  current state, for debug.

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Edge detect: each action input has a registered previous-value flop. A rising edge is input=1 and prev=0.
- Event priority in the same cycle: clear > pause > load (`get_min`/`get_sec`) > start.
- clear, in any state: go to IDLE, pulse `cnt_clr`, `led`←0, prescaler←0.
- IDLE:
  - `get_min` edge → `ld_min` pulse; `get_sec` edge → `ld_sec` pulse. Both edges in one cycle → both strobes in the same cycle.
  - A load in the same cycle as a start edge suppresses the start.
  - start edge: `cnt_up`←`up`; prescaler←0.
    - If `up`=0 and `cnt_zero`=1 → DONE.
    - If `up`=1 and `cnt_max`=1 → DONE.
    - Otherwise → RUN.
- RUN: on each tick, check in this order:
  - `cnt_up`=0 and `cnt_zero`=1 → DONE, no `cnt_en`.
  - `cnt_up`=1 and `cnt_max`=1 → DONE, no `cnt_en`.
  - Otherwise pulse `cnt_en`.
  - Also in RUN: pause edge → PAUSE; start edge is ignored.
- PAUSE: prescaler holds its value. A pause or start edge → RUN, and the prescaler resumes from the held count.
- DONE: `led`=1.
  - start edge → IDLE, `led`←0.
  - `get_min`/`get_sec` edge → load strobe, IDLE, `led`←0.
- Load is only accepted in IDLE and DONE; it is ignored in RUN and PAUSE.
- `ld_digits` conversion: `num`>59 saturates to 59; tens=num/10, units=num%10. Value is registered alongside the strobe.

## Timing
- Reset values: state=IDLE; `ld_digits`=0; `ld_min`, `ld_sec`, `cnt_en`, `cnt_clr`, `led` = 0; `cnt_up`=0; prescaler=0; edge flops=0.
- Strobes and state changes are registered. They take effect at the clock edge where the rising edge is first sampled (input 1, prev 0), and are visible for exactly the following cycle.
- Prescaler counts only in RUN. A tick occurs when the count ≥ DIV−1, where DIV is selected by the current `fast`; the count then wraps to 0.
  - `fast` switched mid-run with count ≥ new DIV−1 → tick on the next RUN cycle.
- The first tick after start occurs DIV cycles after the start edge is sampled.
- `cnt_zero`/`cnt_max` are sampled only on tick cycles. DIV ≥ 2 guarantees the datapath flags have settled after the previous `cnt_en`.
- Asserting `reset` mid-operation forces all reset values immediately. Release is synchronous to `clock` in the instantiating design.

## Structure
- Package `timer_pkg`:
  - State enum (2-bit) and constant `MAX_VAL`=59.
  - Function `bin2bcd(num[5:0])` → 8-bit BCD, with saturation.
- Sub-module `timer_prescaler`: divider with enable, synchronous clear, two divisor parameters, and a `fast` select; outputs `tick`.
- `timer_ctrl` holds the FSM, edge detectors and output registers.

## Test plan
All scenarios use TICK_DIV=10, FAST_DIV=2.
- Load: IDLE, `num`=37, `get_sec` edge → one cycle with `ld_sec`=1, `ld_digits`=8'h37. `num`=63, `get_min` edge → `ld_min`=1, `ld_digits`=8'h59.
- Countdown: `cnt_zero`=0, `up`=0, start edge → `cnt_en` pulses every 10 cycles, `cnt_up`=0. Raise `cnt_zero` → at the next tick, state=DONE, `led`=1, no `cnt_en`.
- Start at terminal: IDLE, `cnt_zero`=1, `up`=0, start edge → DONE next cycle with no `cnt_en`. Start edge again → IDLE, `led`=0.
- Pause/resume: RUN, pause edge at prescaler count 4 → no `cnt_en` for 50 cycles. Pause edge → next `cnt_en` 6 cycles later.
- Fast and up: RUN, `up`=1, `fast`=1 → `cnt_en` every 2 cycles. `cnt_max`=1 → DONE at the next tick.
- Priority and reset: same-cycle clear and pause edges in RUN → IDLE, `cnt_clr` pulse, no PAUSE. Drive `reset` low mid-RUN → all outputs 0, state=IDLE, with no clock edge needed.
